egress_scheduler: RTL and testbench
===================================

EGRESS_SCHEDULER -- requirements
Module: egress_scheduler

Interface
REQ-001 Parameter PORT_NUB_TOTAL, default `PORT_NUB_TOTAL (4): number of switch ports; N below.
REQ-002 Parameter WIDTH_SEL, default $clog2(PORT_NUB_TOTAL): width of one source-select field.
REQ-003 Parameter MAX_BURST, default 4: maximum consecutive reads from one source queue per grant; legal range 1..255.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sched_en  input  1  global enable; 0 blocks new grants.
REQ-007 empty_in  input  N*N  per-output VOQ empty flags; bit [o*N+s] = queue for output o, source s is empty.
REQ-008 tx_ready_in  input  N  per-output downstream ready.
REQ-009 rd_en  output  N  per-output VOQ read strobe, one entry per asserted cycle.
REQ-010 rd_sel  output  N*WIDTH_SEL  per-output source index; field o = bits [(o+1)*WIDTH_SEL-1 : o*WIDTH_SEL].
REQ-011 tx_vld  output  N  per-output data-valid, marks port_out data of the switch.
REQ-012 busy  output  N  per-output arbiter in BURST state.

Function
REQ-013 Each output o SHALL have an independent arbiter with states IDLE and BURST, a round-robin pointer ptr[o] (WIDTH_SEL bits), and a burst counter cnt[o] (8 bits).
REQ-014 IDLE -> BURST when sched_en=1, tx_ready_in[o]=1 and any empty_in[o*N+s]=0; the granted source is the first non-empty s searching ptr[o], ptr[o]+1, ... modulo N.
REQ-015 In the grant cycle and every BURST cycle with tx_ready_in[o]=1 and the granted queue non-empty, rd_en[o]=1 and rd_sel field o = granted source; in that cycle rd_sel is combinationally valid.
REQ-016 rd_en[o] SHALL never assert while empty_in for the selected queue is 1 or tx_ready_in[o] is 0.
REQ-017 cnt[o] loads 1 on grant and increments per read; BURST -> IDLE when cnt[o]=MAX_BURST after a read, when the granted queue reads empty, or when sched_en=0.
REQ-018 tx_ready_in[o]=0 in BURST holds state, source and cnt (no read, no rotation).
REQ-019 On BURST -> IDLE, ptr[o] SHALL become granted source + 1, wrapping N-1 -> 0.
REQ-020 BURST -> IDLE and a new grant MAY occur in the same cycle (back-to-back grant, no idle bubble) when another source is non-empty.
REQ-021 tx_vld[o] SHALL equal rd_en[o] delayed by exactly one cycle (VOQ read latency 1).
REQ-022 When all N queues of output o are empty, rd_en[o]=0 and state stays IDLE.
REQ-023 empty_in is assumed by this block to already reflect reads issued in earlier cycles; no read-ahead is performed.

Reset
REQ-024 With rst=1 at a clock edge: all states IDLE, ptr=0, cnt=0, rd_en=0, rd_sel=0, tx_vld=0, busy=0 from the next cycle.
REQ-025 Reset asserted mid-burst SHALL abort the burst; no rd_en issued in the cycle after the reset edge, and the pending tx_vld is cleared.

Configuration
REQ-026 Macro SCHED_BURST_EN defined: bursting per REQ-017 with MAX_BURST.
REQ-027 SCHED_BURST_EN undefined: MAX_BURST is ignored, cnt logic removed, every grant is exactly one read followed by rotation (pure per-read round-robin).

Structure
REQ-028 Shared package sched_pkg SHALL hold the state encoding (IDLE=1'b0, BURST=1'b1), the WIDTH_SEL derivation and the burst-counter width constant.
REQ-029 One sub-module rr_arbiter (N-input rotating-priority first-one finder, pointer in, index+found out) SHALL be instantiated once per output.

Verification (N=4, MAX_BURST=4)
REQ-030 Output 0, sources 1 and 3 each hold 6 entries, ready=1 -> rd_sel 1,1,1,1,3,3,3,3,1,1,3,3; no idle cycle between grants.
REQ-031 Output 2, only source 0 holds 2 entries -> two rd_en with sel 0, then IDLE, ptr[2]=1; tx_vld[2] high two cycles, starting one cycle after first rd_en.
REQ-032 Output 1 mid-burst after 2 reads, tx_ready_in[1]=0 for 3 cycles -> no rd_en, cnt holds 2; on resume exactly 2 more reads then rotate.
REQ-033 rst pulsed in cycle after 3rd read of a burst -> next cycle rd_en=0, tx_vld=0, ptr=0; next grant restarts search from source 0.
REQ-034 SCHED_BURST_EN undefined, sources 0,1,2 non-empty on output 3 -> rd_sel 0,1,2,0,1,2...; all four outputs run concurrently with independent pointers.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared definitions for the egress scheduler: arbiter state encoding,
// select-width derivation, burst-counter width and a modulo-N increment helper.
// Provides the `PORT_NUB_TOTAL default (4 ports) when not set on the command line.
// Build option: SCHED_BURST_EN (consumed by egress_scheduler).
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

package sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } sched_state_e;

  localparam int unsigned CNT_W = 8;

  // Width of one source-select field; a single port still needs one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // v + 1 modulo n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/egress_scheduler_rr_arbiter.sv
// rr_arbiter: rotating-priority first-one finder.
// Ports:
//   i_req   [N-1:0]  request vector (1 = source has data)
//   i_ptr   [W-1:0]  highest-priority source index
//   o_idx   [W-1:0]  first requesting source at or after i_ptr, modulo N
//   o_found          at least one request present
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // Walk ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    logic [W-1:0] cand;
    o_idx   = '0;
    o_found = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = W'((32'(i_ptr) + k) % N);
      if (!o_found && i_req[cand]) begin
        o_found = 1'b1;
        o_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/egress_scheduler.sv
// egress_scheduler: one independent round-robin VOQ read arbiter per output port.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   sched_en       global enable; low blocks new grants
//   empty_in       N*N VOQ empty flags, bit [o*N+s] = output o / source s
//   tx_ready_in    N   per-output downstream ready
//   rd_en          N   per-output VOQ read strobe (combinational)
//   rd_sel         N*WIDTH_SEL per-output source index (combinational, 0 when idle)
//   tx_vld         N   rd_en delayed one cycle (VOQ read latency)
//   busy           N   arbiter in BURST state
// Build option: SCHED_BURST_EN enables up to MAX_BURST consecutive reads per
// grant; without it every grant is a single read followed by rotation.
module egress_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned PORT_NUB_TOTAL = `PORT_NUB_TOTAL,
  parameter int unsigned WIDTH_SEL      = sel_width(PORT_NUB_TOTAL),
  parameter int unsigned MAX_BURST      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   sched_en,
  input  logic [PORT_NUB_TOTAL*PORT_NUB_TOTAL-1:0] empty_in,
  input  logic [PORT_NUB_TOTAL-1:0]              tx_ready_in,
  output logic [PORT_NUB_TOTAL-1:0]              rd_en,
  output logic [PORT_NUB_TOTAL*WIDTH_SEL-1:0]    rd_sel,
  output logic [PORT_NUB_TOTAL-1:0]              tx_vld,
  output logic [PORT_NUB_TOTAL-1:0]              busy
);

  localparam int unsigned N = PORT_NUB_TOTAL;

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("egress_scheduler: MAX_BURST must be within 1..255");
  end

  // Reads are suppressed during reset and for one cycle after it.
  logic r_rst_q;
  logic w_block;

  always_ff @(posedge clk) r_rst_q <= rst;
  assign w_block = rst | r_rst_q;

  for (genvar o = 0; o < N; o++) begin : g_out
    sched_state_e         r_state;
    logic [WIDTH_SEL-1:0] r_ptr;
    logic [WIDTH_SEL-1:0] r_src;
    logic                 r_tx_vld;

    logic [N-1:0]         w_req;
    logic [WIDTH_SEL-1:0] w_arb_ptr;
    logic [WIDTH_SEL-1:0] w_idx;
    logic [WIDTH_SEL-1:0] w_idx_inc;
    logic [WIDTH_SEL-1:0] w_src_inc;
    logic [WIDTH_SEL-1:0] w_sel;
    logic                 w_found;
    logic                 w_src_avail;
    logic                 w_read;
    logic                 w_grant;
    logic                 w_last;

    assign w_req       = ~empty_in[o*N +: N];
    assign w_src_avail = w_req[r_src];
    assign w_src_inc   = WIDTH_SEL'(wrap_inc(32'(r_src), N));
    assign w_idx_inc   = WIDTH_SEL'(wrap_inc(32'(w_idx), N));
    // In BURST the search starts past the current source so a drained queue
    // hands over to the next source in the same cycle.
    assign w_arb_ptr   = (r_state == ST_BURST) ? w_src_inc : r_ptr;

    rr_arbiter #(
      .N (N),
      .W (WIDTH_SEL)
    ) u_arb (
      .i_req   (w_req),
      .i_ptr   (w_arb_ptr),
      .o_idx   (w_idx),
      .o_found (w_found)
    );

    // Read decision: continue the burst, else take a fresh grant.
    always_comb begin
      w_read  = 1'b0;
      w_grant = 1'b0;
      w_sel   = r_src;
      if (!w_block && tx_ready_in[o]) begin
        if (r_state == ST_BURST && w_src_avail) begin
          w_read = 1'b1;
        end else if (sched_en && w_found) begin
          w_read  = 1'b1;
          w_grant = 1'b1;
          w_sel   = w_idx;
        end
      end
    end

`ifdef SCHED_BURST_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_cnt_nxt = w_grant ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_nxt == CNT_W'(MAX_BURST));

    // Burst length counter: 1 on grant, +1 per continuing read.
    always_ff @(posedge clk) begin
      if (rst)         r_cnt <= '0;
      else if (w_read) r_cnt <= w_cnt_nxt;
    end
`else
    assign w_last = 1'b1;
`endif

    // Per-output arbiter state, pointer and read-latency pipeline.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state  <= ST_IDLE;
        r_ptr    <= '0;
        r_src    <= '0;
        r_tx_vld <= 1'b0;
      end else begin
        r_tx_vld <= w_read;
        case (r_state)
          ST_IDLE: begin
            if (w_grant) begin
              r_src <= w_idx;
              if (w_last) r_ptr   <= w_idx_inc;
              else        r_state <= ST_BURST;
            end
          end
          ST_BURST: begin
            if (!sched_en) begin
              r_state <= ST_IDLE;
              r_ptr   <= w_src_inc;
            end else if (tx_ready_in[o]) begin
              if (w_src_avail) begin
                if (w_last) begin
                  r_state <= ST_IDLE;
                  r_ptr   <= w_src_inc;
                end
              end else if (w_grant) begin
                // Back-to-back handover to the next non-empty source.
                r_src <= w_idx;
                if (w_last) begin
                  r_state <= ST_IDLE;
                  r_ptr   <= w_idx_inc;
                end else begin
                  r_ptr   <= w_src_inc;
                end
              end else begin
                r_state <= ST_IDLE;
                r_ptr   <= w_src_inc;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end

    assign rd_en[o]                          = w_read;
    assign rd_sel[o*WIDTH_SEL +: WIDTH_SEL]  = w_read ? w_sel : '0;
    assign tx_vld[o]                         = r_tx_vld;
    assign busy[o]                           = (r_state == ST_BURST);
  end

endmodule

// File: tb/tb_egress_scheduler.sv
// Self-checking bench for egress_scheduler (N=4, MAX_BURST=4). Queue occupancy is
// kept as per-(output,source) entry counts; a per-output reference model predicts
// every cycle's reads from the round-robin / burst rules. Works with or without
// SCHED_BURST_EN.
module tb_egress_scheduler;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int WS = 2;
`ifdef SCHED_BURST_EN
  localparam int B = MB;
`else
  localparam int B = 1;
`endif

  logic            clk;
  logic            rst;
  logic            sched_en;
  logic [N*N-1:0]  empty_in;
  logic [N-1:0]    tx_ready_in;
  logic [N-1:0]    rd_en;
  logic [N*WS-1:0] rd_sel;
  logic [N-1:0]    tx_vld;
  logic [N-1:0]    busy;

  egress_scheduler #(
    .PORT_NUB_TOTAL (N),
    .WIDTH_SEL      (WS),
    .MAX_BURST      (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sched_en    (sched_en),
    .empty_in    (empty_in),
    .tx_ready_in (tx_ready_in),
    .rd_en       (rd_en),
    .rd_sel      (rd_sel),
    .tx_vld      (tx_vld),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model state
  int cnt_q [N][N];
  int m_ptr [N];
  int m_src [N];
  int m_nrd [N];
  bit m_act [N];
  bit m_txv [N];
  bit m_blk;
  bit exp_en [N];
  int exp_sel [N];

  int cyc;
  int rec_o;
  int seq[$];
  int seq_cyc[$];

  task automatic chk(input string tag, input int o, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, o, obs, want);
    end
  endtask

  task automatic do_read(input int o, input int s);
    exp_en[o]  = 1'b1;
    exp_sel[o] = s;
    cnt_q[o][s]--;
  endtask

  task automatic end_burst(input int o);
    m_act[o] = 1'b0;
    m_ptr[o] = (m_src[o] + 1) % N;
  endtask

  // Round-robin search from the pointer; the grant itself is read number one.
  task automatic try_grant(input int o);
    for (int k = 0; k < N; k++) begin
      int s;
      s = (m_ptr[o] + k) % N;
      if (cnt_q[o][s] > 0) begin
        do_read(o, s);
        m_src[o] = s;
        m_nrd[o] = 1;
        if (B == 1) m_ptr[o] = (s + 1) % N;
        else        m_act[o] = 1'b1;
        break;
      end
    end
  endtask

  task automatic model_step(input int o, input bit rdy, input bit en);
    if (m_act[o]) begin
      if (!en) begin
        if (rdy && cnt_q[o][m_src[o]] > 0) do_read(o, m_src[o]);
        end_burst(o);
      end else if (rdy) begin
        if (cnt_q[o][m_src[o]] > 0) begin
          do_read(o, m_src[o]);
          m_nrd[o]++;
          if (m_nrd[o] == B) end_burst(o);
        end else begin
          end_burst(o);
          try_grant(o);
        end
      end
    end else if (rdy && en) begin
      try_grant(o);
    end
  endtask

  // One clock cycle: drive, predict, compare, advance.
  task automatic cycle(input bit r, input logic [N-1:0] rdy, input bit en);
    rst         = r;
    tx_ready_in = rdy;
    sched_en    = en;
    for (int o = 0; o < N; o++)
      for (int s = 0; s < N; s++)
        empty_in[o*N+s] = (cnt_q[o][s] == 0);
    @(negedge clk);
    for (int o = 0; o < N; o++) begin
      chk("tx_vld", o, 32'(tx_vld[o]), 32'(m_txv[o]));
      chk("busy", o, 32'(busy[o]), 32'(m_act[o]));
      exp_en[o]  = 1'b0;
      exp_sel[o] = 0;
    end
    if (!r && !m_blk)
      for (int o = 0; o < N; o++) model_step(o, rdy[o], en);
    for (int o = 0; o < N; o++) begin
      chk("rd_en", o, 32'(rd_en[o]), 32'(exp_en[o]));
      chk("rd_sel", o, 32'(rd_sel[o*WS +: WS]), 32'(exp_sel[o]));
    end
    if (rec_o >= 0 && rd_en[rec_o]) begin
      seq.push_back(int'(rd_sel[rec_o*WS +: WS]));
      seq_cyc.push_back(cyc);
    end
    if (r) begin
      for (int o = 0; o < N; o++) begin
        m_act[o] = 1'b0;
        m_ptr[o] = 0;
        m_nrd[o] = 0;
        m_txv[o] = 1'b0;
      end
      m_blk = 1'b1;
    end else begin
      for (int o = 0; o < N; o++) m_txv[o] = exp_en[o];
      m_blk = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_list [12];
    int rst_cyc;
    int ro, rs;
    logic [N-1:0] rdy;

    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rec_o    = -1;
    rst      = 1'b1;
    sched_en = 1'b0;
    tx_ready_in = '0;
    empty_in = '1;
    for (int o = 0; o < N; o++) begin
      m_act[o] = 1'b0; m_ptr[o] = 0; m_src[o] = 0; m_nrd[o] = 0; m_txv[o] = 1'b0;
      for (int s = 0; s < N; s++) cnt_q[o][s] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int o = 0; o < N; o++) begin
      chk("rst_rd_en", o, 32'(rd_en[o]), 32'd0);
      chk("rst_rd_sel", o, 32'(rd_sel[o*WS +: WS]), 32'd0);
      chk("rst_tx_vld", o, 32'(tx_vld[o]), 32'd0);
      chk("rst_busy", o, 32'(busy[o]), 32'd0);
    end
    @(posedge clk);
    #1;
    m_blk = 1'b1;

    // All queues empty: nothing happens
    repeat (2) cycle(1'b0, 4'hF, 1'b1);

    // Output 0: sources 1 and 3 with 6 entries each
    cnt_q[0][1] = 6;
    cnt_q[0][3] = 6;
    rec_o = 0; seq.delete(); seq_cyc.delete();
    repeat (16) cycle(1'b0, 4'hF, 1'b1);
    rec_o = -1;
`ifdef SCHED_BURST_EN
    exp_list = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1, 3, 3};
`else
    exp_list = '{1, 3, 1, 3, 1, 3, 1, 3, 1, 3, 1, 3};
`endif
    chk("seq0_len", 0, 32'(seq.size()), 32'd12);
    if (seq.size() == 12) begin
      for (int i = 0; i < 12; i++) chk("seq0_sel", i, 32'(seq[i]), 32'(exp_list[i]));
      chk("seq0_span", 0, 32'(seq_cyc[11] - seq_cyc[0]), 32'd11);
    end

    // Output 2: only source 0, two entries
    cnt_q[2][0] = 2;
    repeat (6) cycle(1'b0, 4'hF, 1'b1);

    // Output 1: stall mid-burst after two reads
    cnt_q[1][2] = 8;
    repeat (2) cycle(1'b0, 4'hF, 1'b1);
    repeat (3) cycle(1'b0, 4'b1101, 1'b1);
    repeat (8) cycle(1'b0, 4'hF, 1'b1);

    // Output 3: reset after the third read, then search restarts at source 0
    cnt_q[3][2] = 6;
    repeat (3) cycle(1'b0, 4'hF, 1'b1);
    cnt_q[3][1] = 2;
    cycle(1'b1, 4'hF, 1'b1);
    rec_o = 3; seq.delete(); seq_cyc.delete();
    rst_cyc = cyc;
    repeat (6) cycle(1'b0, 4'hF, 1'b1);
    rec_o = -1;
    chk("post_rst_reads", 3, 32'(seq.size() > 0), 32'd1);
    if (seq.size() > 0) begin
      chk("post_rst_sel", 3, 32'(seq[0]), 32'd1);
      chk("post_rst_lat", 3, 32'(seq_cyc[0] - rst_cyc), 32'd1);
    end

    // Global disable while idle
    cycle(1'b1, 4'hF, 1'b1);
    cnt_q[0][0] += 3;
    cnt_q[2][3] += 2;
    repeat (3) cycle(1'b0, 4'hF, 1'b0);
    repeat (4) cycle(1'b0, 4'hF, 1'b1);

    // Output 3 with sources 0,1,2 while the other outputs run as well
    cycle(1'b1, 4'hF, 1'b1);
    for (int s = 0; s < N; s++) cnt_q[3][s] = (s < 3) ? 4 : 0;
    cnt_q[0][2] += 3;
    cnt_q[1][0] += 2;
    cnt_q[2][1] += 5;
    rec_o = 3; seq.delete(); seq_cyc.delete();
    repeat (9) cycle(1'b0, 4'hF, 1'b1);
    rec_o = -1;
`ifdef SCHED_BURST_EN
    exp_list = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
`else
    exp_list = '{0, 1, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0};
`endif
    chk("seq3_len_ge6", 3, 32'(seq.size() >= 6), 32'd1);
    if (seq.size() >= 6)
      for (int i = 0; i < 6; i++) chk("seq3_sel", i, 32'(seq[i]), 32'(exp_list[i]));

    // Random traffic and back-pressure
    repeat (400) begin
      if ($urandom_range(3) == 0) begin
        ro = int'($urandom_range(N - 1));
        rs = int'($urandom_range(N - 1));
        cnt_q[ro][rs] += int'($urandom_range(4, 1));
      end
      rdy = N'($urandom | $urandom);
      cycle(1'b0, rdy, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
